// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the multicycle MIPS main decoder.
package mips_mc_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned ALUOP_W = 3;
  localparam int unsigned ST_W    = 5;

  typedef enum logic [ST_W-1:0] {
    FETCH   = 5'd0,
    DECODE  = 5'd1,
    MEMADR  = 5'd2,
    MEMRD   = 5'd3,
    MEMWB   = 5'd4,
    MEMWR   = 5'd5,
    RTYPEEX = 5'd6,
    ALUWB   = 5'd7,
    BEQEX   = 5'd8,
    BNEEX   = 5'd9,
    IMMEX   = 5'd10,
    IMMWB   = 5'd11,
    JEX     = 5'd12,
    JALEX   = 5'd13,
    EXC     = 5'd14
  } statetype;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;

  localparam logic [ALUOP_W-1:0] ALU_ADD   = 3'b000;
  localparam logic [ALUOP_W-1:0] ALU_SUB   = 3'b001;
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = 3'b010;
  localparam logic [ALUOP_W-1:0] ALU_AND   = 3'b011;
  localparam logic [ALUOP_W-1:0] ALU_OR    = 3'b100;
  localparam logic [ALUOP_W-1:0] ALU_SLT   = 3'b101;

  typedef struct packed {
    logic               mem_req;
    logic               memwrite;
    logic               iord;
    logic               irwrite;
    logic [1:0]         regdst;
    logic [1:0]         memtoreg;
    logic               regwrite;
    logic               alusrca;
    logic [1:0]         alusrcb;
    logic [1:0]         pcsrc;
    logic [ALUOP_W-1:0] aluop;
    logic               branch;
    logic               branchne;
    logic               pcwrite;
    logic               illegal_op;
  } ctrl_t;

  // ALU operation for the immediate-arithmetic group.
  function automatic logic [ALUOP_W-1:0] imm_aluop(input logic [OP_W-1:0] op);
    case (op)
      OP_SLTI: imm_aluop = ALU_SLT;
      OP_ANDI: imm_aluop = ALU_AND;
      OP_ORI:  imm_aluop = ALU_OR;
      default: imm_aluop = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/maindec_mc_outrom.sv
// State to control-word decode for maindec_mc_hs (combinational).
// Build option MC_EXC_EN adds the EXC state word.
module maindec_mc_outrom
  import mips_mc_pkg::*;
(
  input  statetype         state,
  input  logic [OP_W-1:0]  op,
  output ctrl_t            ctrl
);

  // FETCH carries irwrite/pcwrite ungated; the top qualifies them with mem_ready.
  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.mem_req = 1'b1;
        ctrl.alusrcb = 2'b01;
        ctrl.aluop   = ALU_ADD;
        ctrl.irwrite = 1'b1;
        ctrl.pcwrite = 1'b1;
      end
      DECODE: begin
        ctrl.alusrcb = 2'b11;
        ctrl.aluop   = ALU_ADD;
      end
      MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
        ctrl.aluop   = ALU_ADD;
      end
      MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
      end
      MEMWB: begin
        ctrl.regdst   = 2'b00;
        ctrl.memtoreg = 2'b01;
        ctrl.regwrite = 1'b1;
      end
      MEMWR: begin
        ctrl.mem_req  = 1'b1;
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      RTYPEEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b00;
        ctrl.aluop   = ALU_FUNCT;
      end
      ALUWB: begin
        ctrl.regdst   = 2'b01;
        ctrl.memtoreg = 2'b00;
        ctrl.regwrite = 1'b1;
      end
      BEQEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALU_SUB;
        ctrl.pcsrc   = 2'b01;
        ctrl.branch  = 1'b1;
      end
      BNEEX: begin
        ctrl.alusrca  = 1'b1;
        ctrl.aluop    = ALU_SUB;
        ctrl.pcsrc    = 2'b01;
        ctrl.branchne = 1'b1;
      end
      IMMEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
        ctrl.aluop   = imm_aluop(op);
      end
      IMMWB: begin
        ctrl.regdst   = 2'b00;
        ctrl.memtoreg = 2'b00;
        ctrl.regwrite = 1'b1;
      end
      JEX: begin
        ctrl.pcsrc   = 2'b10;
        ctrl.pcwrite = 1'b1;
      end
      JALEX: begin
        ctrl.pcsrc    = 2'b10;
        ctrl.pcwrite  = 1'b1;
        ctrl.regdst   = 2'b10;
        ctrl.memtoreg = 2'b10;
        ctrl.regwrite = 1'b1;
      end
`ifdef MC_EXC_EN
      EXC: begin
        ctrl.pcsrc      = 2'b11;
        ctrl.pcwrite    = 1'b1;
        ctrl.illegal_op = 1'b1;
      end
`endif
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/maindec_mc_hs.sv
// Multicycle MIPS main control FSM with variable-latency memory handshake.
// Build option MC_EXC_EN routes illegal opcodes through an exception state.
module maindec_mc_hs
  import mips_mc_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    op,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               memwrite,
  output logic               iord,
  output logic               irwrite,
  output logic [1:0]         regdst,
  output logic [1:0]         memtoreg,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [ALUOP_W-1:0] aluop,
  output logic               branch,
  output logic               branchne,
  output logic               pcwrite,
  output logic               illegal_op,
  output logic [ST_W-1:0]    st
);

  statetype state;
  ctrl_t    ctrl;
  logic     fetch_gate;

  // State register with next-state selection; unknown codes recover to FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:   if (mem_ready) state <= DECODE;
        DECODE: begin
          case (op)
            OP_RTYPE:                          state <= RTYPEEX;
            OP_LW, OP_SW:                      state <= MEMADR;
            OP_BEQ:                            state <= BEQEX;
            OP_BNE:                            state <= BNEEX;
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state <= IMMEX;
            OP_J:                              state <= JEX;
            OP_JAL:                            state <= JALEX;
`ifdef MC_EXC_EN
            default:                           state <= EXC;
`else
            default:                           state <= FETCH;
`endif
          endcase
        end
        MEMADR:  state <= (op == OP_SW) ? MEMWR : MEMRD;
        MEMRD:   if (mem_ready) state <= MEMWB;
        MEMWR:   if (mem_ready) state <= FETCH;
        RTYPEEX: state <= ALUWB;
        IMMEX:   state <= IMMWB;
        default: state <= FETCH;
      endcase
    end
  end

  maindec_mc_outrom u_outrom (
    .state (state),
    .op    (op),
    .ctrl  (ctrl)
  );

  // IR and PC loads in FETCH only happen on the cycle memory delivers.
  assign fetch_gate = (state != FETCH) | mem_ready;

  assign mem_req    = ctrl.mem_req;
  assign memwrite   = ctrl.memwrite;
  assign iord       = ctrl.iord;
  assign irwrite    = ctrl.irwrite & fetch_gate;
  assign regdst     = ctrl.regdst;
  assign memtoreg   = ctrl.memtoreg;
  assign regwrite   = ctrl.regwrite;
  assign alusrca    = ctrl.alusrca;
  assign alusrcb    = ctrl.alusrcb;
  assign pcsrc      = ctrl.pcsrc;
  assign aluop      = ctrl.aluop;
  assign branch     = ctrl.branch;
  assign branchne   = ctrl.branchne;
  assign pcwrite    = ctrl.pcwrite & fetch_gate;
  assign illegal_op = ctrl.illegal_op;
  assign st         = state;

endmodule

// File: tb/tb_maindec_mc_hs.sv
// Directed scoreboard bench for maindec_mc_hs; checks the full output word every cycle.
module tb_maindec_mc_hs;
  import mips_mc_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic [OP_W-1:0]    op;
  logic               mem_ready;
  logic               mem_req, memwrite, iord, irwrite, regwrite, alusrca;
  logic [1:0]         regdst, memtoreg, alusrcb, pcsrc;
  logic [ALUOP_W-1:0] aluop;
  logic               branch, branchne, pcwrite, illegal_op;
  logic [ST_W-1:0]    st;

  int tests_run = 0;
  int tests_failed = 0;

  logic [25:0] exp_q[$];
  string       tag_q[$];

  maindec_mc_hs dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .memwrite   (memwrite),
    .iord       (iord),
    .irwrite    (irwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .aluop      (aluop),
    .branch     (branch),
    .branchne   (branchne),
    .pcwrite    (pcwrite),
    .illegal_op (illegal_op),
    .st         (st)
  );

  always #5 clk = ~clk;

  // Reference control word for a state, written out from the control table.
  function automatic logic [25:0] model(input statetype s, input logic [OP_W-1:0] o,
                                        input logic r);
    logic m_req, m_wr, m_iord, m_ir, m_rw, m_sa, m_br, m_bne, m_pcw, m_ill;
    logic [1:0] m_rd, m_mtr, m_sb, m_pcs;
    logic [2:0] m_alu;
    {m_req, m_wr, m_iord, m_ir, m_rw, m_sa, m_br, m_bne, m_pcw, m_ill} = '0;
    {m_rd, m_mtr, m_sb, m_pcs, m_alu} = '0;
    case (s)
      FETCH:   begin m_req = 1'b1; m_sb = 2'b01; m_ir = r; m_pcw = r; end
      DECODE:  m_sb = 2'b11;
      MEMADR:  begin m_sa = 1'b1; m_sb = 2'b10; end
      MEMRD:   begin m_req = 1'b1; m_iord = 1'b1; end
      MEMWB:   begin m_mtr = 2'b01; m_rw = 1'b1; end
      MEMWR:   begin m_req = 1'b1; m_iord = 1'b1; m_wr = 1'b1; end
      RTYPEEX: begin m_sa = 1'b1; m_alu = 3'b010; end
      ALUWB:   begin m_rd = 2'b01; m_rw = 1'b1; end
      BEQEX:   begin m_sa = 1'b1; m_alu = 3'b001; m_pcs = 2'b01; m_br = 1'b1; end
      BNEEX:   begin m_sa = 1'b1; m_alu = 3'b001; m_pcs = 2'b01; m_bne = 1'b1; end
      IMMEX: begin
        m_sa = 1'b1; m_sb = 2'b10;
        if (o == 6'b001010)      m_alu = 3'b101;
        else if (o == 6'b001100) m_alu = 3'b011;
        else if (o == 6'b001101) m_alu = 3'b100;
        else                     m_alu = 3'b000;
      end
      IMMWB:   m_rw = 1'b1;
      JEX:     begin m_pcs = 2'b10; m_pcw = 1'b1; end
      JALEX:   begin m_pcs = 2'b10; m_pcw = 1'b1; m_rd = 2'b10; m_mtr = 2'b10; m_rw = 1'b1; end
      EXC:     begin m_pcs = 2'b11; m_pcw = 1'b1; m_ill = 1'b1; end
      default: ;
    endcase
    return {m_req, m_wr, m_iord, m_ir, m_rd, m_mtr, m_rw, m_sa, m_sb, m_pcs, m_alu,
            m_br, m_bne, m_pcw, m_ill, 5'(s)};
  endfunction

  // Called just after a falling edge with inputs set; checks, then advances one clock.
  task automatic cyc(input string tag, input statetype es);
    logic [25:0] obs, exp_w;
    string t;
    exp_q.push_back(model(es, op, mem_ready));
    tag_q.push_back(tag);
    #1;
    obs = {mem_req, memwrite, iord, irwrite, regdst, memtoreg, regwrite, alusrca, alusrcb,
           pcsrc, aluop, branch, branchne, pcwrite, illegal_op, st};
    exp_w = exp_q.pop_front();
    t = tag_q.pop_front();
    tests_run++;
    assert (obs === exp_w) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", t, obs, exp_w);
    end
    @(negedge clk);
  endtask

  task automatic two_step(input string tag, input logic [OP_W-1:0] o, input statetype ex);
    op = o;
    mem_ready = 1'b1;
    cyc({tag, "_fetch"}, FETCH);
    cyc({tag, "_decode"}, DECODE);
    cyc({tag, "_ex"}, ex);
  endtask

  initial begin
    reset = 1'b1;
    op = 6'b100011;
    mem_ready = 1'b0;
    @(negedge clk);
    cyc("reset", FETCH);
    reset = 1'b0;

    // FETCH stalls three cycles, then completes with lw
    cyc("fetch_wait1", FETCH);
    cyc("fetch_wait2", FETCH);
    cyc("fetch_wait3", FETCH);
    mem_ready = 1'b1;
    cyc("fetch_ready", FETCH);
    cyc("lw_decode", DECODE);
    cyc("lw_memadr", MEMADR);
    cyc("lw_memrd", MEMRD);
    cyc("lw_memwb", MEMWB);

    // sw with two wait cycles in MEMWR
    op = 6'b101011;
    cyc("sw_fetch", FETCH);
    cyc("sw_decode", DECODE);
    cyc("sw_memadr", MEMADR);
    mem_ready = 1'b0;
    cyc("sw_memwr1", MEMWR);
    cyc("sw_memwr2", MEMWR);
    mem_ready = 1'b1;
    cyc("sw_memwr3", MEMWR);

    op = 6'b000000;
    cyc("r_fetch", FETCH);
    cyc("r_decode", DECODE);
    cyc("r_ex", RTYPEEX);
    cyc("r_wb", ALUWB);

    two_step("addi", 6'b001000, IMMEX); cyc("addi_wb", IMMWB);
    two_step("slti", 6'b001010, IMMEX); cyc("slti_wb", IMMWB);
    two_step("andi", 6'b001100, IMMEX); cyc("andi_wb", IMMWB);
    two_step("ori",  6'b001101, IMMEX); cyc("ori_wb", IMMWB);
    two_step("beq",  6'b000100, BEQEX);
    two_step("bne",  6'b000101, BNEEX);
    two_step("j",    6'b000010, JEX);
    two_step("jal",  6'b000011, JALEX);

    op = 6'b111111;
    cyc("ill_fetch", FETCH);
    cyc("ill_decode", DECODE);
`ifdef MC_EXC_EN
    cyc("ill_exc", EXC);
`endif
    cyc("ill_back", FETCH);

    // reset asserted while MEMRD is waiting on memory
    op = 6'b100011;
    cyc("rst_decode", DECODE);
    cyc("rst_memadr", MEMADR);
    mem_ready = 1'b0;
    cyc("rst_memrd", MEMRD);
    reset = 1'b1;
    cyc("rst_mid_memrd", FETCH);
    reset = 1'b0;
    cyc("rst_after", FETCH);
    mem_ready = 1'b1;
    cyc("rst_resume", FETCH);
    cyc("rst_resume_decode", DECODE);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
